// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared types and constants for the data-memory arbiter
package dmem_arb_pkg;

  localparam int WORD_BYTES = 4;
  localparam int REQ_ADDR_W = 32;

  typedef struct packed {
    logic [REQ_ADDR_W-1:0] addr;
    logic [31:0]           wdata;
    logic [WORD_BYTES-1:0] wmask;
  } req_t;

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - one requester's request/response channel
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [3:0]        req_wmask;
  logic              req_ready;
  logic              rsp_valid;
  logic [31:0]       rsp_data;

  modport master (
    output req_valid, req_addr, req_wdata, req_wmask,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_addr, req_wdata, req_wmask,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// rtl/dmem_arbiter_rr_arb2.sv - two-input round-robin grant with priority pointer
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic prio_q, prio_d;

  // Grant is combinational; nothing is granted while reset is high.
  // The pointer moves away from whichever side was just served.
  always_comb begin
    gnt_o  = 2'b00;
    prio_d = prio_q;
    if (!reset) begin
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = prio_q ? 2'b10 : 2'b01;
        default: gnt_o = 2'b00;
      endcase
    end
    if (gnt_o[0]) begin
      prio_d = 1'b1;
    end else if (gnt_o[1]) begin
      prio_d = 1'b0;
    end
  end

  // Priority pointer register, A first out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares one data-RAM port between two requesters; DMEM_ARB_STATS_EN adds stall counters
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MEM_AW = 14
`ifdef DMEM_ARB_STATS_EN
  , parameter int STAT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              reset,
  dmem_arbiter_if.slave     a_if,
  dmem_arbiter_if.slave     b_if,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wmask,
  output logic              mem_cen,
  input  logic [31:0]       mem_data
`ifdef DMEM_ARB_STATS_EN
  , output logic [STAT_W-1:0] stall_a
  , output logic [STAT_W-1:0] stall_b
`endif
);

  localparam int OFS = $clog2(WORD_BYTES);

  logic [1:0] gnt;
  req_t       req_a, req_b, req_sel;
  logic       accept;

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .reset (reset),
    .req_i ({b_if.req_valid, a_if.req_valid}),
    .gnt_o (gnt)
  );

  assign a_if.req_ready = gnt[0];
  assign b_if.req_ready = gnt[1];
  assign accept         = |gnt;

  // Request mux: granted requester drives the RAM port, idle port is all zero.
  always_comb begin
    req_a   = '{addr: REQ_ADDR_W'(a_if.req_addr), wdata: a_if.req_wdata, wmask: a_if.req_wmask};
    req_b   = '{addr: REQ_ADDR_W'(b_if.req_addr), wdata: b_if.req_wdata, wmask: b_if.req_wmask};
    req_sel = '0;
    if (gnt[0]) begin
      req_sel = req_a;
    end else if (gnt[1]) begin
      req_sel = req_b;
    end
  end

  // Byte offset and bits above the RAM depth are dropped, so the RAM wraps.
  assign mem_addr  = req_sel.addr[MEM_AW+OFS-1:OFS];
  assign mem_wdata = req_sel.wdata;
  assign mem_wmask = req_sel.wmask;
  assign mem_cen   = accept;

  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, req_sel.addr[OFS-1:0], req_sel.addr[REQ_ADDR_W-1:MEM_AW+OFS]};

  owner_e rsp_owner_q, rsp_owner_d;
  logic   rsp_pend_q, rsp_pend_d;
  logic   rsp_wr_q, rsp_wr_d;

  // Response tracker next state: every accept reloads owner and kind.
  always_comb begin
    rsp_pend_d  = accept;
    rsp_owner_d = rsp_owner_q;
    rsp_wr_d    = rsp_wr_q;
    if (accept) begin
      rsp_owner_d = gnt[1] ? OWN_B : OWN_A;
      rsp_wr_d    = |req_sel.wmask;
    end
  end

  // Response tracker registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_pend_q  <= 1'b0;
      rsp_owner_q <= OWN_A;
      rsp_wr_q    <= 1'b0;
    end else begin
      rsp_pend_q  <= rsp_pend_d;
      rsp_owner_q <= rsp_owner_d;
      rsp_wr_q    <= rsp_wr_d;
    end
  end

  // Reset gates the outputs too, so an in-flight response is dropped at once.
  assign a_if.rsp_valid = rsp_pend_q && (rsp_owner_q == OWN_A) && !reset;
  assign b_if.rsp_valid = rsp_pend_q && (rsp_owner_q == OWN_B) && !reset;
  assign a_if.rsp_data  = (a_if.rsp_valid && !rsp_wr_q) ? mem_data : 32'h0;
  assign b_if.rsp_data  = (b_if.rsp_valid && !rsp_wr_q) ? mem_data : 32'h0;

`ifdef DMEM_ARB_STATS_EN
  logic [STAT_W-1:0] stall_a_q, stall_b_q;

  // Saturating stall counters: count cycles a side waits with valid high.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_a_q <= '0;
      stall_b_q <= '0;
    end else begin
      if (a_if.req_valid && !gnt[0] && (stall_a_q != '1)) begin
        stall_a_q <= stall_a_q + 1'b1;
      end
      if (b_if.req_valid && !gnt[1] && (stall_b_q != '1)) begin
        stall_b_q <= stall_b_q + 1'b1;
      end
    end
  end

  assign stall_a = stall_a_q;
  assign stall_b = stall_b_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_cen;
  logic [31:0] mem_data;
  logic [31:0] ram [0:16383];

  int checks = 0;
  int errors = 0;

  dmem_arbiter_if #(.ADDR_W(32)) a_if ();
  dmem_arbiter_if #(.ADDR_W(32)) b_if ();

`ifdef DMEM_ARB_STATS_EN
  logic [3:0] stall_a, stall_b;
  dmem_arbiter #(.MEM_AW(14), .STAT_W(4)) dut (
    .clk(clk), .reset(reset), .a_if(a_if), .b_if(b_if),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_cen(mem_cen), .mem_data(mem_data),
    .stall_a(stall_a), .stall_b(stall_b)
  );
`else
  dmem_arbiter #(.MEM_AW(14)) dut (
    .clk(clk), .reset(reset), .a_if(a_if), .b_if(b_if),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_cen(mem_cen), .mem_data(mem_data)
  );
`endif

  always #5 clk = ~clk;

  // RAM model: byte-masked write, registered old-data read.
  always @(posedge clk) begin
    if (mem_cen) begin
      mem_data <= ram[mem_addr];
      for (int i = 0; i < 4; i++) begin
        if (mem_wmask[i]) ram[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [31:0] ad, input logic [31:0] wd, input logic [3:0] wm);
    a_if.req_valid = v; a_if.req_addr = ad; a_if.req_wdata = wd; a_if.req_wmask = wm;
  endtask

  task automatic drive_b(input logic v, input logic [31:0] ad, input logic [31:0] wd, input logic [3:0] wm);
    b_if.req_valid = v; b_if.req_addr = ad; b_if.req_wdata = wd; b_if.req_wmask = wm;
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) ram[i] = 32'h0;
    ram[4]   = 32'hDEADBEEF;
    ram[8]   = 32'hAABBCCDD;
    ram[2]   = 32'h0BADF00D;
    mem_data = 32'h0;

    // Reset with both requesting: nothing accepted, port idle.
    reset = 1'b1;
    drive_a(1'b1, 32'h10, 32'h0, 4'h0);
    drive_b(1'b1, 32'h20, 32'h0, 4'h0);
    #1;
    chk("rst_a_ready", 32'(a_if.req_ready), 32'h0);
    chk("rst_b_ready", 32'(b_if.req_ready), 32'h0);
    chk("rst_mem_cen", 32'(mem_cen), 32'h0);
    chk("rst_mem_wmask", 32'(mem_wmask), 32'h0);
    cyc();
    cyc();
    chk("rst_a_rsp_valid", 32'(a_if.rsp_valid), 32'h0);
    chk("rst_a_rsp_data", a_if.rsp_data, 32'h0);
    drive_a(1'b0, 32'h0, 32'h0, 4'h0);
    drive_b(1'b0, 32'h0, 32'h0, 4'h0);
    reset = 1'b0;
    cyc();

    // A alone reads 0x10.
    drive_a(1'b1, 32'h10, 32'h0, 4'h0);
    #1;
    chk("rdA_ready", 32'(a_if.req_ready), 32'h1);
    chk("rdA_mem_addr", 32'(mem_addr), 32'h4);
    chk("rdA_mem_cen", 32'(mem_cen), 32'h1);
    cyc();
    drive_a(1'b0, 32'h0, 32'h0, 4'h0);
    chk("rdA_rsp_valid", 32'(a_if.rsp_valid), 32'h1);
    chk("rdA_rsp_data", a_if.rsp_data, 32'hDEADBEEF);
    chk("rdA_b_rsp_valid", 32'(b_if.rsp_valid), 32'h0);

    // A partial write to 0x20, then B reads it back.
    drive_a(1'b1, 32'h20, 32'h11223344, 4'b0011);
    #1;
    chk("wrA_ready", 32'(a_if.req_ready), 32'h1);
    chk("wrA_mem_wmask", 32'(mem_wmask), 32'h3);
    chk("wrA_mem_wdata", mem_wdata, 32'h11223344);
    cyc();
    drive_a(1'b0, 32'h0, 32'h0, 4'h0);
    chk("wrA_ack_valid", 32'(a_if.rsp_valid), 32'h1);
    chk("wrA_ack_data", a_if.rsp_data, 32'h0);
    drive_b(1'b1, 32'h20, 32'h0, 4'h0);
    #1;
    chk("rdB_ready", 32'(b_if.req_ready), 32'h1);
    cyc();
    drive_b(1'b0, 32'h0, 32'h0, 4'h0);
    chk("rdB_rsp_valid", 32'(b_if.rsp_valid), 32'h1);
    chk("rdB_rsp_data", b_if.rsp_data, 32'hAABB3344);
    chk("rdB_a_rsp_valid", 32'(a_if.rsp_valid), 32'h0);

    // Full contention for 6 cycles: A,B,A,B,A,B.
    drive_a(1'b1, 32'h10, 32'h0, 4'h0);
    drive_b(1'b1, 32'h20, 32'h0, 4'h0);
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("cont_a_ready", 32'(a_if.req_ready), (k % 2 == 0) ? 32'h1 : 32'h0);
      chk("cont_b_ready", 32'(b_if.req_ready), (k % 2 == 1) ? 32'h1 : 32'h0);
      chk("cont_mem_cen", 32'(mem_cen), 32'h1);
      cyc();
      chk("cont_a_rsp_valid", 32'(a_if.rsp_valid), (k % 2 == 0) ? 32'h1 : 32'h0);
      chk("cont_b_rsp_valid", 32'(b_if.rsp_valid), (k % 2 == 1) ? 32'h1 : 32'h0);
      chk("cont_rsp_data", (k % 2 == 0) ? a_if.rsp_data : b_if.rsp_data,
          (k % 2 == 0) ? 32'hDEADBEEF : 32'hAABB3344);
    end
    drive_a(1'b0, 32'h0, 32'h0, 4'h0);
    drive_b(1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    chk("idle_mem_cen", 32'(mem_cen), 32'h0);
    chk("idle_mem_addr", 32'(mem_addr), 32'h0);
    cyc();
    chk("idle_a_rsp_valid", 32'(a_if.rsp_valid), 32'h0);
    chk("idle_b_rsp_valid", 32'(b_if.rsp_valid), 32'h0);

    // Address wrap: 0x0004_0008 maps to word 2.
    drive_a(1'b1, 32'h0004_0008, 32'h0, 4'h0);
    #1;
    chk("wrap_mem_addr", 32'(mem_addr), 32'h2);
    cyc();
    drive_a(1'b0, 32'h0, 32'h0, 4'h0);
    chk("wrap_rsp_data", a_if.rsp_data, 32'h0BADF00D);

    // A accepted in cycle N, reset in N+1: response dropped, prio back to A.
    drive_a(1'b1, 32'h10, 32'h0, 4'h0);
    #1;
    chk("midrst_accept", 32'(a_if.req_ready), 32'h1);
    cyc();
    reset = 1'b1;
    #1;
    chk("midrst_rsp_valid", 32'(a_if.rsp_valid), 32'h0);
    chk("midrst_ready", 32'(a_if.req_ready), 32'h0);
    cyc();
    chk("midrst_rsp_after", 32'(a_if.rsp_valid), 32'h0);
    reset = 1'b0;
    drive_b(1'b1, 32'h20, 32'h0, 4'h0);
    #1;
    chk("postrst_a_first", 32'(a_if.req_ready), 32'h1);
    chk("postrst_b_wait", 32'(b_if.req_ready), 32'h0);
    cyc();
    chk("postrst_a_rsp", a_if.rsp_data, 32'hDEADBEEF);
    drive_a(1'b0, 32'h0, 32'h0, 4'h0);
    drive_b(1'b0, 32'h0, 32'h0, 4'h0);

`ifdef DMEM_ARB_STATS_EN
    // Stall counters: 4 contended cycles, A first, then run into saturation.
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("stat_rst_a", 32'(stall_a), 32'h0);
    drive_a(1'b1, 32'h10, 32'h0, 4'h0);
    drive_b(1'b1, 32'h20, 32'h0, 4'h0);
    for (int k = 0; k < 4; k++) cyc();
    chk("stat_a_4cyc", 32'(stall_a), 32'h2);
    chk("stat_b_4cyc", 32'(stall_b), 32'h2);
    for (int k = 0; k < 36; k++) cyc();
    chk("stat_a_sat", 32'(stall_a), 32'hF);
    chk("stat_b_sat", 32'(stall_b), 32'hF);
    drive_a(1'b0, 32'h0, 32'h0, 4'h0);
    drive_b(1'b0, 32'h0, 32'h0, 4'h0);
    cyc();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares one synchronous data-memory port between two requesters (hart A, hart B) in the TORVS dual-issue build.
- The port has byte-masked writes and a 1-cycle registered read.
- Each requester uses a valid/ready request channel and a valid-only response channel.
- Round-robin arbitration with back-to-back issue: one access per cycle sustained.
- Sits between the core LSUs and one port of the data RAM (memdual / data_mem / Gowin_DPB).

Parameters:
- ADDR_W, 32, requester byte-address width.
- MEM_AW, 14, memory word-address width; mem_addr = req_addr[MEM_AW+1:2].
- STAT_W, 16, width of stall counters (optional feature only).

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- a_req_valid  in  1  requester A access request.
- a_req_addr  in  ADDR_W  A byte address.
- a_req_wdata  in  32  A write data.
- a_req_wmask  in  4  A byte write mask; 0 = read.
- a_req_ready  out  1  A request accepted this cycle.
- a_rsp_valid  out  1  A response (read data or write ack).
- a_rsp_data  out  32  A read data.
- b_req_valid, b_req_addr, b_req_wdata, b_req_wmask, b_req_ready, b_rsp_valid, b_rsp_data: same as A, for requester B.
- mem_addr  out  MEM_AW  word address to RAM.
- mem_wdata  out  32  write data to RAM.
- mem_wmask  out  4  byte enables; write enable = |mem_wmask.
- mem_cen  out  1  RAM clock/port enable, high on any granted access.
- mem_data  in  32  RAM read data, valid 1 cycle after an access with mem_cen high.
- stall_a, stall_b  out  STAT_W  stall counters (only with DMEM_ARB_STATS_EN).

Behaviour:
- Grant is combinational in the request cycle.
  - Only one valid: that requester is granted.
  - Both valid: grant goes to the requester named by the priority pointer `prio` (0 = A, 1 = B).
  - After any granted access, `prio` moves to the other requester.
  - Neither valid: `prio` holds.
  - Reset value of `prio` is 0 (A first).
- x_req_ready = grant_x. The request is accepted when x_req_valid and x_req_ready are both high in the same cycle. Requesters hold all request fields stable until accepted.
- Memory drive:
  - In the grant cycle, mem_addr/mem_wdata/mem_wmask come from the granted requester and mem_cen = 1.
  - With no grant: mem_cen = 0, mem_wmask = 0, mem_addr/mem_wdata = 0.
- Response tracking: registers rsp_owner (A/B) and rsp_pend (1 bit) are loaded on every accept; rsp_pend clears the next cycle unless a new accept occurs.
- Response timing, both reads and writes:
  - x_rsp_valid pulses exactly 1 cycle after acceptance.
  - a_rsp_data / b_rsp_data = mem_data when that side's rsp_valid is high, else 0.
  - Write responses carry rsp_data = 0 and act as an ack.
- Throughput: accepts may occur every cycle. Alternating A/B under full contention gives each side 1 access per 2 cycles. Maximum wait for a held request is 1 cycle.
- Response channel never back-pressures; requesters must always accept responses.
- Address bits [1:0] are ignored. Address bits above MEM_AW+1 are ignored, so the RAM wraps modulo 2^MEM_AW words.
- Simultaneous A write and B read to the same word: granted in turn, so the one granted first completes first. Memory read-during-write is old-data and is never exercised by this block, because only one access issues per cycle.
- Reset mid-operation:
  - Clears prio, rsp_pend and rsp_owner (and the stall counters if compiled in).
  - Any in-flight response is dropped: no rsp_valid the cycle after reset.
  - A request present during reset is not accepted; ready = 0 while reset is high.
- Reset values: all ready = 0, rsp_valid = 0, rsp_data = 0, mem_cen = 0, mem_wmask = 0.

Optional Feature:
- Macro DMEM_ARB_STATS_EN.
- Defined:
  - stall_a/stall_b increment by 1 each cycle that side has valid high and ready low.
  - Counters saturate at all-ones and clear on reset.
- Undefined: the stall ports are absent and there is no counter logic.

Decomposition:
- Package dmem_arb_pkg holds:
  - typedef req_t {addr, wdata, wmask};
  - enum owner_e {OWN_A, OWN_B};
  - localparam WORD_BYTES = 4.
- One sub-module rr_arb2: 2-input round-robin grant with the prio register, inputs req[1:0], output gnt[1:0], advance on any grant.
- The arbiter top instantiates rr_arb2, the request mux and the response tracker.

Test Plan:
- Reset then only A: reads addr 0x10 with RAM word 4 = 0xDEADBEEF. Expect a_req_ready same cycle, a_rsp_valid next cycle with 0xDEADBEEF, b_rsp_valid = 0.
- Both requesters valid continuously for 6 cycles. Expect grants A,B,A,B,A,B, each rsp_valid exactly one cycle after its grant, mem_cen high all 6 cycles.
- A writes 0x11223344 with wmask 4'b0011 to 0x20 over old 0xAABBCCDD, then B reads 0x20. Expect b_rsp_data = 0xAABB3344.
- Read at addr 0x0004_0008 with MEM_AW = 14. Expect mem_addr = 2 (wrap).
- A accepted in cycle N, reset asserted in cycle N+1. Expect no a_rsp_valid in N+1, prio = A after reset, ready = 0 during reset.
- With DMEM_ARB_STATS_EN: A and B contend for 4 cycles with A granted first. Expect stall_a = 2 and stall_b = 2; a counter preset near all-ones saturates rather than wrapping.
